// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the decoder side and the sequential ALU.
// The master side drives the operands and accepts results; the slave side is the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [7:0]       Selector;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] X_hi;
  logic [7:0]       Flags;

  modport master (
    output in_valid, A, B, Selector, out_ready,
    input  in_ready, out_valid, X, X_hi, Flags
  );

  modport slave (
    input  in_valid, A, B, Selector, out_ready,
    output in_ready, out_valid, X, X_hi, Flags
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops, iterative shift-add multiply
// and restoring divide, with valid/ready handshakes and registered results and flags.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_OR   = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;
  localparam logic [7:0] OP_NOT  = 8'h07;
  localparam logic [7:0] OP_NAND = 8'h08;
  localparam logic [7:0] OP_NOR  = 8'h09;
  localparam logic [7:0] OP_XNOR = 8'h0A;
  localparam logic [7:0] OP_DIV  = 8'h0B;
  localparam logic [7:0] OP_SHL  = 8'h0C;
  localparam logic [7:0] OP_SHR  = 8'h0D;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic parity8(input logic [7:0] v);
    parity8 = ~^v;
  endfunction

  function automatic logic [7:0] pack_flags(input logic zf, input logic cf, input logic sf,
                                            input logic pf, input logic of_f, input logic de);
    pack_flags = {de, of_f, 2'b00, pf, sf, cf, zf};
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       op_q;
  logic [WIDTH-1:0] opb_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] x_q, x_hi_q;
  logic [7:0]       flags_q;
  logic             in_ready_q, out_valid_q;

  logic [CNT_W-1:0] amt_s;
  logic [WIDTH:0]   arith_s, shl_s, shr_s;
  logic [WIDTH-1:0] sc_x_d, sc_hi_d;
  logic [7:0]       sc_flags_d;
  logic             sc_cf_s, sc_of_s, sc_def_s;

  logic [WIDTH:0]   mul_sum_s, div_sh_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] step_hi_d, step_lo_d;
  logic [7:0]       step_flags_d;

  assign amt_s         = bus.B[CNT_W-1:0];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.X         = x_q;
  assign bus.X_hi      = x_hi_q;
  assign bus.Flags     = flags_q;

  // Single-cycle result and flags computed from the live operands at accept time.
  always_comb begin
    arith_s  = '0;
    shl_s    = '0;
    shr_s    = '0;
    sc_x_d   = '0;
    sc_hi_d  = '0;
    sc_cf_s  = 1'b0;
    sc_of_s  = 1'b0;
    sc_def_s = 1'b1;
    case (bus.Selector)
      OP_ADD: begin
        arith_s = {1'b0, bus.A} + {1'b0, bus.B};
        sc_x_d  = arith_s[MSB:0];
        sc_cf_s = arith_s[WIDTH];
        sc_of_s = (bus.A[MSB] == bus.B[MSB]) && (sc_x_d[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        arith_s = {1'b0, bus.A} - {1'b0, bus.B};
        sc_x_d  = arith_s[MSB:0];
        sc_cf_s = arith_s[WIDTH];
        sc_of_s = (bus.A[MSB] != bus.B[MSB]) && (sc_x_d[MSB] != bus.A[MSB]);
      end
      OP_AND:  sc_x_d = bus.A & bus.B;
      OP_OR:   sc_x_d = bus.A | bus.B;
      OP_XOR:  sc_x_d = bus.A ^ bus.B;
      OP_NOT:  sc_x_d = ~bus.A;
      OP_NAND: sc_x_d = ~(bus.A & bus.B);
      OP_NOR:  sc_x_d = ~(bus.A | bus.B);
      OP_XNOR: sc_x_d = ~(bus.A ^ bus.B);
      // The extra bit beside the operand catches the last bit shifted out.
      OP_SHL: begin
        shl_s   = {1'b0, bus.A} << amt_s;
        sc_x_d  = shl_s[MSB:0];
        sc_cf_s = shl_s[WIDTH];
      end
      OP_SHR: begin
        shr_s   = {bus.A, 1'b0} >> amt_s;
        sc_x_d  = shr_s[WIDTH:1];
        sc_cf_s = shr_s[0];
      end
      OP_DIV: begin
        sc_x_d  = '1;
        sc_hi_d = bus.A;
      end
      default: sc_def_s = 1'b0;
    endcase
    if (bus.Selector == OP_DIV) begin
      sc_flags_d = pack_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end else if (sc_def_s) begin
      sc_flags_d = pack_flags(sc_x_d == '0, sc_cf_s, sc_x_d[MSB], parity8(sc_x_d[7:0]),
                              sc_of_s, 1'b0);
    end else begin
      sc_flags_d = 8'h00;
    end
  end

  // One multiply (shift-add) or divide (restore-subtract) iteration plus final flags.
  always_comb begin
    mul_sum_s  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_sh_s   = {acc_hi_q, acc_lo_q[MSB]};
    div_ge_s   = (div_sh_s >= {1'b0, opb_q});
    div_diff_s = div_sh_s[MSB:0] - opb_q;
    if (op_q == OP_MUL) begin
      step_hi_d    = mul_sum_s[WIDTH:1];
      step_lo_d    = {mul_sum_s[0], acc_lo_q[MSB:1]};
      step_flags_d = pack_flags((step_hi_d == '0) && (step_lo_d == '0), step_hi_d != '0,
                                step_lo_d[MSB], parity8(step_lo_d[7:0]), step_hi_d != '0, 1'b0);
    end else begin
      step_hi_d    = div_ge_s ? div_diff_s : div_sh_s[MSB:0];
      step_lo_d    = {acc_lo_q[MSB-1:0], div_ge_s};
      step_flags_d = pack_flags(step_lo_d == '0, 1'b0, step_lo_d[MSB],
                                parity8(step_lo_d[7:0]), 1'b0, 1'b0);
    end
  end

  // Control FSM with registered handshake outputs, results and iteration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 8'h00;
      opb_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      x_q         <= '0;
      x_hi_q      <= '0;
      flags_q     <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.Selector;
            opb_q      <= bus.B;
            acc_lo_q   <= bus.A;
            acc_hi_q   <= '0;
            in_ready_q <= 1'b0;
            if ((bus.Selector == OP_MUL) || ((bus.Selector == OP_DIV) && (bus.B != '0))) begin
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= CALC;
            end else begin
              x_q         <= sc_x_d;
              x_hi_q      <= sc_hi_d;
              flags_q     <= sc_flags_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        CALC: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            x_q         <= step_lo_d;
            x_hi_q      <= step_hi_d;
            flags_q     <= step_flags_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational 8-bit ALU. Operand width is generic.
- Adds iterative multiply (full double-width product) and restoring divide (quotient + remainder), plus shifts.
- Uses valid/ready handshakes on both input and output. Results and flags are registered.
- Sits between the register file/decoder and the writeback/flags register of the processor datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 8 or more.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block can accept a new operation.
- A  in  WIDTH  operand A; the dividend for DIV.
- B  in  WIDTH  operand B; the divisor for DIV; the shift amount for SHL/SHR, using its low CNT_W bits.
- Selector  in  8  opcode, listed under Behaviour.
- out_valid  out  1  X, X_hi and Flags hold a finished result.
- out_ready  in  1  consumer accepts the result.
- X  out  WIDTH  result low part: sum/diff/logic/shift result, low half of the product, or the quotient.
- X_hi  out  WIDTH  high half of the product; remainder for DIV; 0 for all other ops.
- Flags  out  8  bit0 ZF, bit1 CF, bit2 SF, bit3 PF, bit6 OF, bit7 DE (divide error); bits 4 and 5 always 0.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, X=0, X_hi=0, Flags=0, counter=0, internal accumulators=0.
  - Reset asserted mid-operation aborts the operation; no result is ever presented.
- Opcodes:
  - 01 ADD, 02 SUB, 03 MUL, 04 AND, 05 OR, 06 XOR, 07 NOT (uses A only), 08 NAND, 09 NOR, 0A XNOR.
  - 0B DIV (unsigned), 0C SHL, 0D SHR (logical).
  - Any other value: result 0, Flags 0, single-cycle path.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch A, B and Selector. Single-cycle ops go to DONE on the next edge with results registered. MUL and DIV go to CALC with counter=WIDTH.
  - CALC: in_ready=0. One shift-add (MUL) or one restore-subtract (DIV) step per cycle; counter decrements each cycle. At counter==1, register the results and go to DONE.
  - DONE: out_valid=1, in_ready=0. Outputs are held stable until out_ready. When out_valid and out_ready are both 1, go to IDLE next edge with out_valid=0; X, X_hi and Flags keep their last values.
- Latency from accept to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL and DIV: WIDTH+1 cycles.
  - Throughput is one operation per 2 cycles at best; there is no overlap, because in_ready is low in DONE.
- Arithmetic and width rules:
  - ADD/SUB use WIDTH+1-bit internal arithmetic. CF is the carry out, or the borrow when A<B. OF is signed overflow, using the same formulas as the 8-bit ALU.
  - MUL is unsigned; the 2*WIDTH product goes to {X_hi, X}. CF=OF=1 when X_hi is nonzero.
  - DIV: X=A/B, X_hi=A%B.
  - DIV with B==0 goes straight to DONE after 1 cycle with X=all-ones, X_hi=A, DE=1, and ZF/CF/SF/PF/OF=0.
  - SHL/SHR: a shift amount of WIDTH or more gives 0. CF is the last bit shifted out, or 0 for an amount of 0. OF=0.
  - Logic ops: CF=OF=0.
- Common flags for every defined op:
  - ZF=(X==0). For MUL, ZF is 1 only if the whole product is 0.
  - SF=X[WIDTH-1].
  - PF=~^X[7:0], following 8086 convention.
- Handshake rules:
  - in_valid while in_ready=0 is ignored.
  - A, B and Selector may change freely after acceptance, because they are latched.
  - out_ready while out_valid=0 is ignored.

Test Plan:
- ADD 0x7F+0x01 (WIDTH=8) -> one cycle after accept: X=0x80, ZF=0, CF=0, SF=1, OF=1, PF=0.
- SUB 0x05-0x07 -> X=0xFE, CF=1, SF=1, OF=0, ZF=0.
- MUL 0xFF*0xFF -> out_valid exactly 9 cycles after accept; X=0x01, X_hi=0xFE, CF=OF=1, ZF=0.
- DIV 200/7 -> X=28 (0x1C), X_hi=4 after 9 cycles. DIV 5/0 -> X=0xFF, X_hi=0x05, DE=1 after 1 cycle.
- Backpressure: out_ready held 0 for 5 cycles after an ADD -> out_valid stays 1, X/Flags stable, in_ready=0, and a new in_valid is ignored. out_ready=1 -> IDLE next cycle, then the new op is accepted.
- Async reset: rst_n low at cycle 4 of a MUL -> out_valid=0, in_ready=1, Flags=0 immediately. After release, ADD 3+4 -> X=7 normally.
